// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer and its control decoder.
package serial_alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] SL_OP_AND  = 2'd0;
  localparam logic [1:0] SL_OP_OR   = 2'd1;
  localparam logic [1:0] SL_OP_SUM  = 2'd2;
  localparam logic [1:0] SL_OP_LESS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/serial_alu_decode.sv
// Maps an ALU control code onto the 1-bit slice configuration and operation class.
module serial_alu_decode
  import serial_alu_pkg::*;
(
  input  logic [3:0] alu_ctrl,
  output logic       a_inv,
  output logic       b_inv,
  output logic [1:0] op,
  output logic       cin0,
  output logic       is_arith,
  output logic       is_slt,
  output logic       legal
);

  always_comb begin
    a_inv    = 1'b0;
    b_inv    = 1'b0;
    op       = SL_OP_AND;
    cin0     = 1'b0;
    is_arith = 1'b0;
    is_slt   = 1'b0;
    legal    = 1'b1;
    case (alu_ctrl)
      CTRL_AND: op = SL_OP_AND;
      CTRL_OR:  op = SL_OP_OR;
      CTRL_ADD: begin
        op       = SL_OP_SUM;
        is_arith = 1'b1;
      end
      CTRL_SUB: begin
        b_inv    = 1'b1;
        op       = SL_OP_SUM;
        cin0     = 1'b1;
        is_arith = 1'b1;
      end
      CTRL_SLT: begin
        b_inv  = 1'b1;
        op     = SL_OP_SUM;
        cin0   = 1'b1;
        is_slt = 1'b1;
      end
      CTRL_NOR: begin
        a_inv = 1'b1;
        b_inv = 1'b1;
        op    = SL_OP_AND;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: drives an external 1-bit ALU slice LSB first and
// assembles the result and flags behind valid/ready handshakes.
module serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             sl_src1,
  output logic             sl_src2,
  output logic             sl_less,
  output logic             sl_a_inv,
  output logic             sl_b_inv,
  output logic             sl_cin,
  output logic [1:0]       sl_op,
  input  logic             sl_result,
  input  logic             sl_cout
);

  localparam int unsigned      IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic             zero_q, zero_d, cout_q, cout_d, overflow_q, overflow_d;

  logic [3:0]       ctrl_sel;
  logic             dec_a_inv, dec_b_inv, dec_cin0, dec_is_arith, dec_is_slt, dec_legal;
  logic [1:0]       dec_op;
  logic             run;
  logic [WIDTH-1:0] acc_next, final_res;
  logic             ovf_msb;

  // In IDLE the live code is decoded so the carry register can load cin0 on accept.
  assign ctrl_sel = (state_q == ST_IDLE) ? alu_ctrl : ctrl_q;

  serial_alu_decode u_decode (
    .alu_ctrl (ctrl_sel),
    .a_inv    (dec_a_inv),
    .b_inv    (dec_b_inv),
    .op       (dec_op),
    .cin0     (dec_cin0),
    .is_arith (dec_is_arith),
    .is_slt   (dec_is_slt),
    .legal    (dec_legal)
  );

  // Operands shift right each bit, so bit i is always presented from position 0.
  assign run      = (state_q == ST_RUN);
  assign sl_src1  = run & dec_legal & a_q[0];
  assign sl_src2  = run & dec_legal & b_q[0];
  assign sl_less  = 1'b0;
  assign sl_a_inv = run & dec_a_inv;
  assign sl_b_inv = run & dec_b_inv;
  assign sl_cin   = run & carry_q;
  assign sl_op    = run ? dec_op : SL_OP_AND;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    overflow_d  = overflow_q;
    acc_next    = {sl_result, acc_q[WIDTH-1:1]};
    // carry_q is the MSB carry-in on the last bit; sl_cout is the MSB carry-out.
    ovf_msb     = carry_q ^ sl_cout;
    final_res   = acc_next;
    if (!dec_legal) begin
      final_res = '0;
    end else if (dec_is_slt) begin
      final_res    = '0;
      final_res[0] = sl_result ^ ovf_msb;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_RUN;
          a_d        = src_a;
          b_d        = src_b;
          ctrl_d     = alu_ctrl;
          idx_d      = '0;
          acc_d      = '0;
          carry_d    = dec_cin0;
          in_ready_d = 1'b0;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = acc_next;
        carry_d = sl_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d     = ST_DONE;
          idx_d       = '0;
          out_valid_d = 1'b1;
          result_d    = final_res;
          zero_d      = (final_res == '0);
          cout_d      = dec_is_arith & sl_cout;
          overflow_d  = dec_is_arith & ovf_msb;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;

endmodule
